// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver with comma-based byte alignment (HUNT -> ALIGN -> LOCKED).
// Optional macro SERIAL_PARALLEL_WORD_COUNT_EN adds the saturating rx_word_cnt output.
module serial_parallel #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in_serial,
    output logic [7:0]  data_out_8b,
    output logic        valid_out,
    output logic        word_strobe,
    output logic        locked,
    output logic [1:0]  dbg_state_o
`ifdef SERIAL_PARALLEL_WORD_COUNT_EN
    ,
    output logic [15:0] rx_word_cnt
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_CNT4 = LOCK_COUNT[3:0];

    state_e      state_q;
    logic [6:0]  sr_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  comma_cnt_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        strobe_q;
    logic        locked_q;

    logic [7:0]  word_d;
    logic        word_done_d;
    logic [3:0]  comma_cnt_d;

    // word_d already contains the bit being sampled at this edge, so outputs
    // registered from it appear with no extra pipeline stage.
    always_comb begin
        word_d      = {sr_q, data_in_serial};
        word_done_d = (bit_cnt_q == 3'd7);
        comma_cnt_d = comma_cnt_q + 4'd1;
    end

`ifdef SERIAL_PARALLEL_WORD_COUNT_EN
    logic [15:0] word_cnt_q;
    assign rx_word_cnt = word_cnt_q;
`endif

    // valid_out has no ready: it qualifies data_out_8b for the whole 8-cycle
    // word period, and word_strobe marks the single cycle the word changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            locked_q    <= 1'b0;
`ifdef SERIAL_PARALLEL_WORD_COUNT_EN
            word_cnt_q  <= '0;
`endif
        end else begin
            sr_q     <= word_d[6:0];
            strobe_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (word_d == COMMA) begin
                        bit_cnt_q   <= 3'd0;
                        comma_cnt_q <= 4'd1;
                        state_q     <= ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (word_done_d) begin
                        if (word_d == COMMA) begin
                            comma_cnt_q <= comma_cnt_d;
                            if (comma_cnt_d == LOCK_CNT4) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            comma_cnt_q <= 4'd0;
                            state_q     <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (word_done_d) begin
                        data_q   <= word_d;
                        valid_q  <= (word_d != COMMA);
                        strobe_q <= 1'b1;
`ifdef SERIAL_PARALLEL_WORD_COUNT_EN
                        if (word_d != COMMA && word_cnt_q != 16'hFFFF)
                            word_cnt_q <= word_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign data_out_8b = data_q;
    assign valid_out   = valid_q;
    assign word_strobe = strobe_q;
    assign locked      = locked_q;
    assign dbg_state_o = state_q;

endmodule
